// File: rtl/mic_capture.sv
// SPI reader for a PmodMIC3 (ADCS7476-style 12-bit ADC): periodic conversion
// framing, 16-bit shift-in, sample/valid/frame_err outputs and a held loud flag.
module mic_capture #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 2500,
  parameter int THRESH        = 512,
  parameter int HOLD          = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        pmod_cs,
  output logic        pmod_sclk,
  input  logic        pmod_sdata,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        frame_err,
  output logic        loud
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = $clog2(HOLD + 1);

  localparam logic [1:0]    S_IDLE = 2'd0;
  localparam logic [1:0]    S_CONV = 2'd1;
  localparam logic [1:0]    S_DONE = 2'd2;
  localparam logic [TW-1:0] TMAX   = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DMAX   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HLOAD  = HW'(HOLD);
  localparam logic [11:0]   MID    = 12'h800;
  localparam logic [11:0]   THR    = 12'(THRESH);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    rise_q, rise_d;
  logic [15:0]   shift_q, shift_d;
  logic [1:0]    sync_q, sync_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic [11:0]   sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          eval_q, eval_d;
  logic          loud_q, loud_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          tick;
  logic [11:0]   mag;

  assign tick = en && (tmr_q == TMAX);

  always_comb begin
    tmr_d = '0;
    if (en && !tick) tmr_d = tmr_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    rise_d   = rise_q;
    shift_d  = shift_q;
    sync_d   = {sync_q[0], pmod_sdata};
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b1;
        if (tick) begin
          state_d = S_CONV;
          cs_d    = 1'b0;
          div_d   = '0;
          rise_d  = '0;
        end
      end
      S_CONV: begin
        if (rise_q == 5'd16) begin
          // 16th rising edge already shifted in; close the frame and report.
          state_d  = S_DONE;
          cs_d     = 1'b1;
          sclk_d   = 1'b1;
          sample_d = shift_q[11:0];
          valid_d  = 1'b1;
          err_d    = |shift_q[15:12];
        end else begin
          div_d = (div_q == DMAX) ? '0 : div_q + 1'b1;
          if (div_q == DMAX) begin
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              shift_d = {shift_q[14:0], sync_q[1]};
              rise_d  = rise_q + 5'd1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  // Offset-binary distance from mid-rail; saturates naturally at 0x800.
  always_comb begin
    mag = (sample_q >= MID) ? (sample_q - MID) : (MID - sample_q);
  end

  always_comb begin
    eval_d = valid_q;
    loud_d = loud_q;
    hold_d = hold_q;
    if (eval_q && en) begin
      if (mag >= THR) begin
        loud_d = 1'b1;
        hold_d = HLOAD;
      end else if (loud_q) begin
        hold_d = hold_q - 1'b1;
        if (hold_q == HW'(1)) loud_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      div_q    <= '0;
      rise_q   <= '0;
      shift_q  <= '0;
      sync_q   <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
      sample_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      eval_q   <= 1'b0;
      loud_q   <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      div_q    <= div_d;
      rise_q   <= rise_d;
      shift_q  <= shift_d;
      sync_q   <= sync_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      eval_q   <= eval_d;
      loud_q   <= loud_d;
      hold_q   <= hold_d;
    end
  end

  assign pmod_cs      = cs_q;
  assign pmod_sclk    = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign loud         = loud_q;

endmodule

// File: tb/tb_mic_capture.sv
// Directed bench for mic_capture with a behavioural ADC that shifts on sclk falls.
module tb_mic_capture;

  logic        clk = 1'b0;
  logic        rst, en, pmod_sdata;
  logic        pmod_cs, pmod_sclk;
  logic [11:0] sample;
  logic        sample_valid, frame_err, loud;

  int n_cmp = 0;
  int n_err = 0;

  mic_capture #(.CLK_DIV(4), .SAMPLE_PERIOD(200), .THRESH(512), .HOLD(3)) dut (
    .clk(clk), .rst(rst), .en(en),
    .pmod_cs(pmod_cs), .pmod_sclk(pmod_sclk), .pmod_sdata(pmod_sdata),
    .sample(sample), .sample_valid(sample_valid), .frame_err(frame_err), .loud(loud)
  );

  always #5 clk = ~clk;

  // ADC model: MSB at cs fall, falling edge k presents word[16-k].
  logic [15:0] adc_word = 16'h0000;
  int          adc_falls = 0;
  logic        adc_sclk_prev = 1'b1;
  always @(negedge clk) begin
    if (pmod_cs) begin
      adc_falls  = 0;
      pmod_sdata = adc_word[15];
    end else if (adc_sclk_prev && !pmod_sclk) begin
      adc_falls++;
      pmod_sdata = (adc_falls <= 16) ? adc_word[16 - adc_falls] : 1'b0;
    end
    adc_sclk_prev = pmod_sclk;
  end

  // Frame monitor.
  int   cyc = 0, fall_cyc = 0, prev_fall_cyc = 0;
  int   low_cnt = 0, last_low = 0, rises = 0, last_rises = 0, valid_cnt = 0;
  logic m_cs = 1'b1, m_sclk = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (m_cs && !pmod_cs) begin
      prev_fall_cyc = fall_cyc;
      fall_cyc      = cyc;
      low_cnt       = 0;
      rises         = 0;
    end
    if (!pmod_cs) low_cnt++;
    if (!m_sclk && pmod_sclk && !pmod_cs) rises++;
    if (!m_cs && pmod_cs) begin
      last_low   = low_cnt;
      last_rises = rises;
    end
    if (sample_valid) valid_cnt++;
    m_cs   = pmod_cs;
    m_sclk = pmod_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      nclk();
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  task automatic wait_cs_fall(input string tag, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      nclk();
      if (!pmod_cs) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  logic [11:0] loud_smp [10] = '{12'h800, 12'h800, 12'h800,
                                 12'h800, 12'hA00, 12'h7FF, 12'h800, 12'h800, 12'h601, 12'h600};
  logic        loud_exp [10] = '{1'b1, 1'b1, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int n, v0, lowseen;
    rst = 1'b1;
    en  = 1'b1;
    pmod_sdata = 1'b0;
    adc_word = 16'h0ABC;
    repeat (5) @(posedge clk);
    nclk();
    chk("rst_cs", pmod_cs, 1);
    chk("rst_sclk", pmod_sclk, 1);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_loud", loud, 0);

    // Release mid-cycle; cs drops after the 200th edge, i.e. in the 201st cycle.
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (!pmod_cs) begin
        n = i;
        break;
      end
    end
    chk("first_cs_fall_edges", n, 200);

    wait_valid("valid_abc", 300);
    chk("sample_abc", sample, 12'hABC);
    chk("err_abc", frame_err, 0);
    chk("cs_low_len", last_low, 129);
    chk("sclk_rises", last_rises, 16);
    v0 = valid_cnt;
    nclk();
    chk("valid_single", sample_valid, 0);
    chk("valid_count", valid_cnt, v0);

    adc_word = 16'h8123;
    wait_valid("valid_8123", 300);
    chk("frame_spacing", fall_cyc - prev_fall_cyc, 200);
    chk("sample_8123", sample, 12'h123);
    chk("err_8123", frame_err, 1);
    nclk();
    chk("err_pulse", frame_err, 0);

    adc_word = 16'h0123;
    wait_valid("valid_0123", 300);
    chk("sample_0123", sample, 12'h123);
    chk("err_0123", frame_err, 0);

    // Three quiet samples first to drain the hold left by the earlier loud words.
    for (int k = 0; k < 10; k++) begin
      adc_word = {4'h0, loud_smp[k]};
      wait_valid("valid_loud", 300);
      chk("sample_loud", sample, loud_smp[k]);
      nclk();
      nclk();
      chk($sformatf("loud_%0d", k), loud, loud_exp[k]);
    end

    // en dropped 50 cycles into a frame.
    adc_word = 16'h0555;
    wait_cs_fall("endrop_cs_fall", 300);
    repeat (50) nclk();
    en = 1'b0;
    wait_valid("valid_endrop", 200);
    chk("sample_endrop", sample, 12'h555);
    lowseen = 0;
    for (int i = 0; i < 1000; i++) begin
      nclk();
      if (!pmod_cs) lowseen++;
    end
    chk("endrop_cs_idle", lowseen, 0);

    // Reset 60 cycles into a frame.
    en = 1'b1;
    adc_word = 16'h0FFF;
    wait_cs_fall("rst_cs_fall", 300);
    repeat (60) nclk();
    v0 = valid_cnt;
    rst = 1'b1;
    nclk();
    chk("abort_cs", pmod_cs, 1);
    chk("abort_sclk", pmod_sclk, 1);
    chk("abort_valid", sample_valid, 0);
    chk("abort_sample", sample, 0);
    repeat (3) nclk();
    chk("abort_no_valid", valid_cnt, v0);
    adc_word = 16'h0321;
    rst = 1'b0;
    wait_valid("valid_after_rst", 400);
    chk("sample_after_rst", sample, 12'h321);
    chk("err_after_rst", frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
